// File: rtl/eea_inv_sequencer.sv
// ---------------------------------------------------------------------------
// eea_inv_sequencer
//
// Control sequencer for the Extended Euclidean GF(2^M) inversion array.
// A start request loads the datapath (R=F, S=A, U=0, V=1). The sequencer
// then runs exactly 2*M iterations and finishes with a one-cycle done pulse.
// Each iteration decodes the array's MSBs (rm, sm) together with the
// degree-difference counter delta into the registered control word
// Switch/Reduce/MultR/MultU.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   inversion request, sampled only in IDLE
//   rm, sm  in   degree-M coefficients of R and S from the array
//   load    out  one-cycle datapath load strobe
//   busy    out  high while LOAD, RUN or DONE
//   done    out  one-cycle pulse; the final control word is valid with it
//   Switch  out  swap R<->S and U<->V
//   Reduce  out  S=S-R, V=V-U
//   MultR   out  compute x.R
//   MultU   out  1: x.U mod F, 0: U/x mod F
//   delta   out  degree-difference counter (saturates at M)
//   iter    out  iterations completed in the current run
//   ovf     out  sticky: delta tried to go past M (cleared by LOAD or rst)
// ---------------------------------------------------------------------------
module eea_inv_sequencer #(
    parameter int M  = 7,
    parameter int DW = $clog2(M + 1),
    parameter int IW = $clog2(2 * M + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rm,
    input  logic          sm,
    output logic          load,
    output logic          busy,
    output logic          done,
    output logic          Switch,
    output logic          Reduce,
    output logic          MultR,
    output logic          MultU,
    output logic [DW-1:0] delta,
    output logic [IW-1:0] iter,
    output logic          ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // The RUN edge that sees this count completes iteration 2*M.
    localparam logic [IW-1:0] ITER_LAST = IW'(2 * M - 1);
    localparam logic [DW-1:0] DELTA_MAX = DW'(M);

    logic [1:0]    state_q,  state_d;
    logic [DW-1:0] delta_q,  delta_d;
    logic [IW-1:0] iter_q,   iter_d;
    logic          ovf_q,    ovf_d;
    logic          switch_q, switch_d;
    logic          reduce_q, reduce_d;
    logic          multr_q,  multr_d;
    logic          multu_q,  multu_d;
    logic          delta_zero;

    assign delta_zero = (delta_q == '0);

    always_comb begin
        state_d  = state_q;
        delta_d  = delta_q;
        iter_d   = iter_q;
        ovf_d    = ovf_q;
        // The control word only survives RUN edges; every other edge clears it.
        switch_d = 1'b0;
        reduce_d = 1'b0;
        multr_d  = 1'b0;
        multu_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                delta_d = '0;
                iter_d  = '0;
                ovf_d   = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                multr_d  = ~rm;
                multu_d  = ~rm | delta_zero;
                switch_d = rm & delta_zero;
                reduce_d = rm & sm;
                // delta==0 always takes the increment branch, so the
                // decrement can never wrap below zero.
                if (~rm | delta_zero) begin
                    if (delta_q == DELTA_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        delta_d = delta_q + DW'(1);
                    end
                end else begin
                    delta_d = delta_q - DW'(1);
                end
                iter_d = iter_q + IW'(1);
                if (iter_q == ITER_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            delta_q  <= '0;
            iter_q   <= '0;
            ovf_q    <= 1'b0;
            switch_q <= 1'b0;
            reduce_q <= 1'b0;
            multr_q  <= 1'b0;
            multu_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            delta_q  <= delta_d;
            iter_q   <= iter_d;
            ovf_q    <= ovf_d;
            switch_q <= switch_d;
            reduce_q <= reduce_d;
            multr_q  <= multr_d;
            multu_q  <= multu_d;
        end
    end

    // Handshake outputs decode straight from the state register, so an
    // asynchronous reset drops them in the same instant as the state.
    assign load   = (state_q == S_LOAD);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign Switch = switch_q;
    assign Reduce = reduce_q;
    assign MultR  = multr_q;
    assign MultU  = multu_q;
    assign delta  = delta_q;
    assign iter   = iter_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_eea_inv_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for eea_inv_sequencer.
// Main instance M=7 is checked every cycle against a timeline model: the
// model counts edges since the accepted start and applies the iteration
// rules with plain integer arithmetic. Directed sections pin the model with
// hand-computed values; two extra instances (M=3, M=163) cover run length
// and saturation for other field sizes.
// ---------------------------------------------------------------------------
module tb_eea_inv_sequencer;

    localparam int M    = 7;
    localparam int DW   = $clog2(M + 1);
    localparam int IW   = $clog2(2 * M + 1);
    localparam int MA   = 3;
    localparam int DWA  = $clog2(MA + 1);
    localparam int IWA  = $clog2(2 * MA + 1);
    localparam int MB   = 163;
    localparam int DWB  = $clog2(MB + 1);
    localparam int IWB  = $clog2(2 * MB + 1);

    logic clk = 1'b0;
    logic rst, start, rm, sm;
    logic load, busy, done, Switch, Reduce, MultR, MultU, ovf;
    logic [DW-1:0] delta;
    logic [IW-1:0] iter;

    logic start_a, start_b;
    logic load_a, busy_a, done_a, sw_a, red_a, mr_a, mu_a, ovf_a;
    logic [DWA-1:0] delta_a;
    logic [IWA-1:0] iter_a;
    logic load_b, busy_b, done_b, sw_b, red_b, mr_b, mu_b, ovf_b;
    logic [DWB-1:0] delta_b;
    logic [IWB-1:0] iter_b;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: m_t = edges since the accepted start edge, -1 when idle
    int m_t, m_delta, m_iter, m_ovf, m_sw, m_red, m_mr, m_mu;
    int run_no = 0;

    always #5 clk = ~clk;

    eea_inv_sequencer #(.M(M)) u_dut (
        .clk(clk), .rst(rst), .start(start), .rm(rm), .sm(sm),
        .load(load), .busy(busy), .done(done), .Switch(Switch), .Reduce(Reduce),
        .MultR(MultR), .MultU(MultU), .delta(delta), .iter(iter), .ovf(ovf)
    );

    eea_inv_sequencer #(.M(MA)) u_m3 (
        .clk(clk), .rst(rst), .start(start_a), .rm(1'b0), .sm(1'b0),
        .load(load_a), .busy(busy_a), .done(done_a), .Switch(sw_a), .Reduce(red_a),
        .MultR(mr_a), .MultU(mu_a), .delta(delta_a), .iter(iter_a), .ovf(ovf_a)
    );

    eea_inv_sequencer #(.M(MB)) u_m163 (
        .clk(clk), .rst(rst), .start(start_b), .rm(1'b0), .sm(1'b0),
        .load(load_b), .busy(busy_b), .done(done_b), .Switch(sw_b), .Reduce(red_b),
        .MultR(mr_b), .MultU(mu_b), .delta(delta_b), .iter(iter_b), .ovf(ovf_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t = -1; m_delta = 0; m_iter = 0; m_ovf = 0;
        m_sw = 0; m_red = 0; m_mr = 0; m_mu = 0;
    endtask

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_step();
        bit dz;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_t < 0) begin
            if (start) m_t = 0;
            return;
        end
        if (m_t >= 1 && m_t <= 2 * M) begin
            dz    = (m_delta == 0);
            m_mr  = !rm;
            m_mu  = (!rm || dz);
            m_sw  = (rm && dz);
            m_red = (rm && sm);
            if (!rm || dz) begin
                if (m_delta == M) m_ovf = 1;
                else m_delta = m_delta + 1;
            end else begin
                m_delta = m_delta - 1;
            end
            m_iter = m_iter + 1;
        end else begin
            m_sw = 0; m_red = 0; m_mr = 0; m_mu = 0;
            if (m_t == 0) begin
                m_delta = 0; m_iter = 0; m_ovf = 0;
            end
        end
        m_t = m_t + 1;
        if (m_t > 2 * M + 1) m_t = -1;
    endtask

    task automatic compare_model();
        chk("load",   32'(load),   32'(m_t == 0));
        chk("busy",   32'(busy),   32'(m_t >= 0));
        chk("done",   32'(done),   32'(m_t == 2 * M + 1));
        chk("Switch", 32'(Switch), 32'(m_sw));
        chk("Reduce", 32'(Reduce), 32'(m_red));
        chk("MultR",  32'(MultR),  32'(m_mr));
        chk("MultU",  32'(MultU),  32'(m_mu));
        chk("delta",  32'(delta),  32'(m_delta));
        chk("iter",   32'(iter),   32'(m_iter));
        chk("ovf",    32'(ovf),    32'(m_ovf));
        if (done) begin
            run_no++;
            $display("run %0d done: iter=%0d delta=%0d ovf=%0d", run_no, iter, delta, ovf);
        end
    endtask

    // One clock: inputs applied at the preceding negedge, model stepped at
    // the posedge, DUT compared at the following negedge.
    task automatic cycle(input logic st, input logic r, input logic s);
        start = st; rm = r; sm = s;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic rnd_cycle(input logic st);
        cycle(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic finish_run(input string nm);
        int k;
        k = 0;
        while (busy && k < 40) begin
            rnd_cycle(1'b0);
            k++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, load_n, done_n, done_at, ovf_first, e;
        int d_at_done, i_at_done, o_at_done;
        int run_a, run_b, dly_a, dly_b, itr_a, itr_b, ov_a, ov_b;
        bit seen_a, seen_b;

        rst = 1'b1; start = 1'b0; rm = 1'b0; sm = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_model();
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // --- first two RUN edges, hand-computed ---
        cycle(1'b1, 1'b0, 1'b0);
        chk("pin_load_after_start", 32'(load), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("pin_e1_Switch", 32'(Switch), 32'd1);
        chk("pin_e1_Reduce", 32'(Reduce), 32'd1);
        chk("pin_e1_MultU",  32'(MultU),  32'd1);
        chk("pin_e1_MultR",  32'(MultR),  32'd0);
        chk("pin_e1_delta",  32'(delta),  32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("pin_e2_word", {28'd0, Switch, Reduce, MultU, MultR}, 32'd0);
        chk("pin_e2_delta", 32'(delta), 32'd0);
        finish_run("pin_run_timeout");
        cycle(1'b0, 1'b0, 1'b0);

        // --- rm=0 for a whole run: handshake timing and saturation ---
        busy_n = 0; load_n = 0; done_n = 0; done_at = -1; ovf_first = -1;
        d_at_done = -1; i_at_done = -1; o_at_done = -1;
        for (e = 0; e <= 2 * M + 4; e++) begin
            cycle(e == 0, 1'b0, 1'($urandom_range(0, 1)));
            if (busy) busy_n++;
            if (load) load_n++;
            if (ovf && ovf_first < 0) ovf_first = e;
            if (done) begin
                done_n++; done_at = e;
                d_at_done = int'(delta); i_at_done = int'(iter); o_at_done = int'(ovf);
            end
        end
        chk("hs_busy_cycles", 32'(busy_n), 32'd16);
        chk("hs_load_cycles", 32'(load_n), 32'd1);
        chk("hs_done_cycles", 32'(done_n), 32'd1);
        chk("hs_done_edge",   32'(done_at), 32'd15);
        chk("hs_iter_at_done",  32'(i_at_done), 32'd14);
        chk("hs_delta_at_done", 32'(d_at_done), 32'd7);
        chk("hs_ovf_at_done",   32'(o_at_done), 32'd1);
        chk("hs_ovf_first_edge", 32'(ovf_first), 32'd9);

        // --- start held high: ignored during the run, relaunches after IDLE ---
        cycle(1'b1, 1'b0, 1'b0);
        e = 0;
        while (!done && e < 40) begin
            cycle(1'b1, 1'b0, 1'b0);
            e++;
        end
        chk("held_done_seen", 32'(done), 32'd1);
        chk("held_ovf_before", 32'(ovf), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("held_idle_gap", 32'(busy), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("held_reload", 32'(load), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("held_ovf_cleared", 32'(ovf), 32'd0);
        finish_run("held_run_timeout");

        // --- reset mid-run at iter=5, delta=3 ---
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("rst_pre_iter",  32'(iter),  32'd5);
        chk("rst_pre_delta", 32'(delta), 32'd3);
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {22'd0, load, busy, done, Switch, Reduce, MultR, MultU, ovf, 2'd0}, 32'd0);
        chk("rst_async_delta", 32'(delta), 32'd0);
        chk("rst_async_iter",  32'(iter),  32'd0);
        model_reset();
        cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("rst_restart_load", 32'(load), 32'd1);
        finish_run("rst_run_timeout");

        // --- randomized runs ---
        for (int r = 0; r < 20; r++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) rnd_cycle(1'b0);
            rnd_cycle(1'b1);
            e = 0;
            while (busy && e < 40) begin
                rnd_cycle(1'($urandom_range(0, 3) == 0));
                e++;
            end
            chk("rand_run_timeout", 32'(busy), 32'd0);
        end
        rnd_cycle(1'b0);

        // --- parameter sweep: M=3 and M=163 with rm held at 0 ---
        run_a = 0; run_b = 0; dly_a = -1; dly_b = -1;
        itr_a = -1; itr_b = -1; ov_a = -1; ov_b = -1;
        seen_a = 1'b0; seen_b = 1'b0;
        start_a = 1'b1; start_b = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        start_a = 1'b0; start_b = 1'b0;
        e = 0;
        while (!(seen_a && seen_b) && e < 400) begin
            if (busy_a && !load_a && !done_a) run_a++;
            if (busy_b && !load_b && !done_b) run_b++;
            if (done_a && !seen_a) begin
                seen_a = 1'b1; dly_a = int'(delta_a); itr_a = int'(iter_a); ov_a = int'(ovf_a);
            end
            if (done_b && !seen_b) begin
                seen_b = 1'b1; dly_b = int'(delta_b); itr_b = int'(iter_b); ov_b = int'(ovf_b);
            end
            cycle(1'b0, 1'b0, 1'b0);
            e++;
        end
        chk("m3_done_seen",   32'(seen_a), 32'd1);
        chk("m3_run_cycles",  32'(run_a),  32'd6);
        chk("m3_delta_sat",   32'(dly_a),  32'd3);
        chk("m3_iter",        32'(itr_a),  32'd6);
        chk("m3_ovf",         32'(ov_a),   32'd1);
        chk("m163_done_seen",  32'(seen_b), 32'd1);
        chk("m163_run_cycles", 32'(run_b),  32'd326);
        chk("m163_delta_sat",  32'(dly_b),  32'd163);
        chk("m163_iter",       32'(itr_b),  32'd326);
        chk("m163_ovf",        32'(ov_b),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
